// File: rtl/rf_wb_pkg.sv
// Shared constants and entry type for the register-file writeback block.
//   RF_AW / RF_DW  : register address / data width of the 32x32 file
//   RF_WB_DEPTH    : default load-result buffer depth
//   wb_entry_t     : one load-buffer slot at the default widths
package rf_wb_pkg;
  localparam int RF_AW       = 5;
  localparam int RF_DW       = 32;
  localparam int RF_WB_DEPTH = 4;

  typedef struct packed {
    logic             valid;
    logic [RF_AW-1:0] wa;
    logic [RF_DW-1:0] wd;
  } wb_entry_t;
endpackage

// File: rtl/rf_wb_if.sv
// Bus bundle between the writeback block and its surroundings.
//   master : the writeback block (drives ld_ready, write port, forwarded data, pending)
//   slave  : producers / decode / register file side
interface rf_wb_if import rf_wb_pkg::*; #(
  parameter int DEPTH = RF_WB_DEPTH,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [AW-1:0] alu_wa;
  logic [DW-1:0] alu_wd;
  logic          ld_valid;
  logic [AW-1:0] ld_wa;
  logic [DW-1:0] ld_wd;
  logic          ld_ready;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] ra1, ra2;
  logic [DW-1:0] rf_rd1, rf_rd2;
  logic [DW-1:0] rd1, rd2;
  logic [CW-1:0] pending;

  modport master (
    input  alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
           ra1, ra2, rf_rd1, rf_rd2,
    output ld_ready, we3, wa3, wd3, rd1, rd2, pending
  );
  modport slave (
    output alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
           ra1, ra2, rf_rd1, rf_rd2,
    input  ld_ready, we3, wa3, wd3, rd1, rd2, pending
  );
endinterface

// File: rtl/rf_wb_buffer.sv
// Killable ring buffer of load results.
//   push_*   : store {wa,wd} at tail as a valid entry
//   pop_i    : retire the head entry (caller guarantees count != 0)
//   kill_*   : clear valid on every stored entry whose wa matches
//   head_*   : current head entry, count_o : occupied slots (live + killed)
//   lk_*     : per read port, youngest valid entry matching lk_ra_i
module rf_wb_buffer import rf_wb_pkg::*; #(
  parameter int DEPTH = RF_WB_DEPTH,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW,
  parameter int NP    = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [AW-1:0]          push_wa_i,
  input  logic [DW-1:0]          push_wd_i,
  input  logic                   pop_i,
  input  logic                   kill_i,
  input  logic [AW-1:0]          kill_wa_i,
  output logic                   head_vld_o,
  output logic [AW-1:0]          head_wa_o,
  output logic [DW-1:0]          head_wd_o,
  output logic [CW-1:0]          count_o,
  input  logic [NP-1:0][AW-1:0]  lk_ra_i,
  output logic [NP-1:0]          lk_hit_o,
  output logic [NP-1:0][DW-1:0]  lk_wd_o
);
  logic [DEPTH-1:0]         vld_q;
  logic [DEPTH-1:0][AW-1:0] wa_q;
  logic [DEPTH-1:0][DW-1:0] wd_q;
  logic [PW-1:0]            head_q, tail_q, lk_idx;
  logic [CW-1:0]            count_q, count_d;

  assign count_d    = count_q + CW'(push_i) - CW'(pop_i);
  assign head_vld_o = vld_q[head_q];
  assign head_wa_o  = wa_q[head_q];
  assign head_wd_o  = wd_q[head_q];
  assign count_o    = count_q;

  // Slots outside [head, tail) always hold valid=0 (pop clears it), so kill
  // and lookup only need to look at valid bits, not ring membership.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_i && vld_q[i] && wa_q[i] == kill_wa_i) vld_q[i] <= 1'b0;
      if (pop_i) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      // Push lands on an empty slot, after the kill: a same-cycle push is
      // younger than the ALU write and survives.
      if (push_i) begin
        vld_q[tail_q] <= 1'b1;
        wa_q[tail_q]  <= push_wa_i;
        wd_q[tail_q]  <= push_wd_i;
        tail_q        <= tail_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Walk back from tail-1; the first valid match is the youngest.
  always_comb begin
    lk_hit_o = '0;
    lk_wd_o  = '0;
    lk_idx   = '0;
    for (int p = 0; p < NP; p++)
      for (int k = 1; k <= DEPTH; k++) begin
        lk_idx = tail_q - PW'(k);
        if (!lk_hit_o[p] && vld_q[lk_idx] && wa_q[lk_idx] == lk_ra_i[p]) begin
          lk_hit_o[p] = 1'b1;
          lk_wd_o[p]  = wd_q[lk_idx];
        end
      end
  end
endmodule

// File: rtl/rf_writeback.sv
// Writeback initiator for the register file's single write port.
//   clk, rst_n : clock, async active-low reset
//   bus        : ALU / load producers, write port we3/wa3/wd3, read
//                forwarding ra/rf_rd -> rd, ld_ready and pending
// ALU results write immediately; loads queue and drain into idle slots.
module rf_writeback import rf_wb_pkg::*; #(
  parameter int DEPTH = RF_WB_DEPTH,
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst_n,
  rf_wb_if.master bus
);
  logic                 alu_wr, push, pop, ld_rdy;
  logic                 head_vld;
  logic [AW-1:0]        head_wa;
  logic [DW-1:0]        head_wd;
  logic [CW-1:0]        count;
  logic [1:0][AW-1:0]   ra;
  logic [1:0][DW-1:0]   rf_rd, lk_wd, rd;
  logic [1:0]           lk_hit;

  assign alu_wr = bus.alu_valid && bus.alu_wa != '0;
  assign ld_rdy = count < CW'(DEPTH);
  // r0 loads complete the handshake but are never stored.
  assign push   = bus.ld_valid && ld_rdy && bus.ld_wa != '0;
  // A killed head retires even while the ALU owns the port.
  assign pop    = count != '0 && (!head_vld || !alu_wr);

  rf_wb_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .NP(2)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .push_wa_i (bus.ld_wa),
    .push_wd_i (bus.ld_wd),
    .pop_i     (pop),
    .kill_i    (alu_wr),
    .kill_wa_i (bus.alu_wa),
    .head_vld_o(head_vld),
    .head_wa_o (head_wa),
    .head_wd_o (head_wd),
    .count_o   (count),
    .lk_ra_i   (ra),
    .lk_hit_o  (lk_hit),
    .lk_wd_o   (lk_wd)
  );

  always_comb begin
    bus.we3 = 1'b0;
    bus.wa3 = '0;
    bus.wd3 = '0;
    if (alu_wr) begin
      bus.we3 = 1'b1;
      bus.wa3 = bus.alu_wa;
      bus.wd3 = bus.alu_wd;
    end else if (count != '0 && head_vld) begin
      bus.we3 = 1'b1;
      bus.wa3 = head_wa;
      bus.wd3 = head_wd;
    end
  end

  assign ra    = {bus.ra2, bus.ra1};
  assign rf_rd = {bus.rf_rd2, bus.rf_rd1};

  always_comb begin
    rd = '0;
    for (int n = 0; n < 2; n++) begin
      if (ra[n] == '0)                             rd[n] = '0;
      else if (bus.alu_valid && bus.alu_wa == ra[n]) rd[n] = bus.alu_wd;
      else if (lk_hit[n])                          rd[n] = lk_wd[n];
      else                                         rd[n] = rf_rd[n];
    end
  end

  assign bus.rd1      = rd[0];
  assign bus.rd2      = rd[1];
  assign bus.ld_ready = ld_rdy;
  assign bus.pending  = count;
endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;
  localparam logic [31:0] RF1 = 32'hEEEE_0001;
  localparam logic [31:0] RF2 = 32'hEEEE_0002;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_wa;
    logic [31:0] alu_wd;
    logic        ld_v;
    logic [4:0]  ld_wa;
    logic [31:0] ld_wd;
    logic [4:0]  ra1, ra2;
    logic        e_rdy, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_rd1, e_rd2;
    logic [2:0]  e_pend;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  rf_wb_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();

  rf_writeback #(.DEPTH(4), .DW(32), .AW(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  function automatic vec_t mk(
    logic av, logic [4:0] awa, logic [31:0] awd,
    logic lv, logic [4:0] lwa, logic [31:0] lwd,
    logic [4:0] r1, logic [4:0] r2,
    logic rdy, logic we, logic [4:0] wa, logic [31:0] wd,
    logic [31:0] d1, logic [31:0] d2, logic [2:0] pend);
    vec_t v;
    v.alu_v = av; v.alu_wa = awa; v.alu_wd = awd;
    v.ld_v = lv; v.ld_wa = lwa; v.ld_wd = lwd;
    v.ra1 = r1; v.ra2 = r2;
    v.e_rdy = rdy; v.e_we = we; v.e_wa = wa; v.e_wd = wd;
    v.e_rd1 = d1; v.e_rd2 = d2; v.e_pend = pend;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] awa, input logic [31:0] awd,
                       input logic lv, input logic [4:0] lwa, input logic [31:0] lwd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.alu_valid = av; bus.alu_wa = awa; bus.alu_wd = awd;
    bus.ld_valid = lv; bus.ld_wa = lwa; bus.ld_wd = lwd;
    bus.ra1 = r1; bus.ra2 = r2;
  endtask

  initial begin
    bus.rf_rd1 = RF1;
    bus.rf_rd2 = RF2;
    drive(0, 0, 0, 0, 0, 0, 1, 2);

    //         alu v wa  wd       ld v wa  wd       ra1 ra2  rdy we wa  wd       rd1      rd2      pend
    // reset state, then plain ALU write with r0 read
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        1,  2,   1, 0, 0,  0,       RF1,     RF2,     0));
    tbl.push_back(mk(1, 3, 32'hA5,   0, 0, 0,        3,  0,   1, 1, 3,  32'hA5,  32'hA5,  0,       0));
    // load r5 buffered behind three ALU writes to r6
    tbl.push_back(mk(1, 6, 32'h66,   1, 5, 32'h11,   5,  6,   1, 1, 6,  32'h66,  RF1,     32'h66,  0));
    tbl.push_back(mk(1, 6, 32'h67,   0, 0, 0,        5,  6,   1, 1, 6,  32'h67,  32'h11,  32'h67,  1));
    tbl.push_back(mk(1, 6, 32'h68,   0, 0, 0,        5,  6,   1, 1, 6,  32'h68,  32'h11,  32'h68,  1));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        5,  6,   1, 1, 5,  32'h11,  32'h11,  RF2,     1));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        5,  6,   1, 0, 0,  0,       RF1,     RF2,     0));
    // kill: r7 load overwritten by ALU before it drains
    tbl.push_back(mk(0, 0, 0,        1, 7, 32'h22,   7,  6,   1, 0, 0,  0,       RF1,     RF2,     0));
    tbl.push_back(mk(1, 7, 32'h33,   0, 0, 0,        7,  6,   1, 1, 7,  32'h33,  32'h33,  RF2,     1));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        7,  6,   1, 0, 0,  0,       RF1,     RF2,     1));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        7,  6,   1, 0, 0,  0,       RF1,     RF2,     0));
    // fill buffer while ALU busy, then drain in order
    tbl.push_back(mk(1, 1, 32'h1,    1, 8, 32'h80,   3,  4,   1, 1, 1,  32'h1,   RF1,     RF2,     0));
    tbl.push_back(mk(1, 1, 32'h2,    1, 9, 32'h90,   3,  4,   1, 1, 1,  32'h2,   RF1,     RF2,     1));
    tbl.push_back(mk(1, 1, 32'h3,    1, 10, 32'hA0,  3,  4,   1, 1, 1,  32'h3,   RF1,     RF2,     2));
    tbl.push_back(mk(1, 1, 32'h4,    1, 11, 32'hB0,  3,  4,   1, 1, 1,  32'h4,   RF1,     RF2,     3));
    tbl.push_back(mk(1, 1, 32'h5,    1, 12, 32'hC0,  11, 8,   0, 1, 1,  32'h5,   32'hB0,  32'h80,  4));
    tbl.push_back(mk(0, 0, 0,        1, 12, 32'hC0,  8,  12,  0, 1, 8,  32'h80,  32'h80,  RF2,     4));
    tbl.push_back(mk(0, 0, 0,        1, 12, 32'hC0,  12, 9,   1, 1, 9,  32'h90,  RF1,     32'h90,  3));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        12, 11,  1, 1, 10, 32'hA0,  32'hC0,  32'hB0,  3));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        3,  4,   1, 1, 11, 32'hB0,  RF1,     RF2,     2));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        3,  4,   1, 1, 12, 32'hC0,  RF1,     RF2,     1));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        3,  4,   1, 0, 0,  0,       RF1,     RF2,     0));
    // r0 handling
    tbl.push_back(mk(0, 0, 0,        1, 0, 32'h55,   0,  0,   1, 0, 0,  0,       0,       0,       0));
    tbl.push_back(mk(1, 0, 32'h77,   0, 0, 0,        0,  5,   1, 0, 0,  0,       0,       RF2,     0));
    // youngest-match forwarding, ALU priority, multi-kill, killed pop under ALU
    tbl.push_back(mk(0, 0, 0,        1, 5, 32'h51,   5,  0,   1, 0, 0,  0,       RF1,     0,       0));
    tbl.push_back(mk(1, 9, 32'h99,   1, 5, 32'h52,   5,  9,   1, 1, 9,  32'h99,  32'h51,  32'h99,  1));
    tbl.push_back(mk(1, 9, 32'h9A,   0, 0, 0,        5,  9,   1, 1, 9,  32'h9A,  32'h52,  32'h9A,  2));
    tbl.push_back(mk(1, 5, 32'h5F,   0, 0, 0,        5,  9,   1, 1, 5,  32'h5F,  32'h5F,  RF2,     2));
    tbl.push_back(mk(1, 2, 32'h20,   0, 0, 0,        5,  9,   1, 1, 2,  32'h20,  RF1,     RF2,     2));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        5,  9,   1, 0, 0,  0,       RF1,     RF2,     1));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        5,  9,   1, 0, 0,  0,       RF1,     RF2,     0));

    // reset state while held
    @(negedge clk);
    #1;
    nvec++;
    chk("rst.ld_ready", 32'(bus.ld_ready), 1);
    chk("rst.pending",  32'(bus.pending),  0);
    chk("rst.we3",      32'(bus.we3),      0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].alu_v, tbl[i].alu_wa, tbl[i].alu_wd,
            tbl[i].ld_v, tbl[i].ld_wa, tbl[i].ld_wd, tbl[i].ra1, tbl[i].ra2);
      #1;
      nvec++;
      chk($sformatf("v%0d.ld_ready", i), 32'(bus.ld_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d.we3", i),      32'(bus.we3),      32'(tbl[i].e_we));
      chk($sformatf("v%0d.wa3", i),      32'(bus.wa3),      32'(tbl[i].e_wa));
      chk($sformatf("v%0d.wd3", i),      bus.wd3,           tbl[i].e_wd);
      chk($sformatf("v%0d.rd1", i),      bus.rd1,           tbl[i].e_rd1);
      chk($sformatf("v%0d.rd2", i),      bus.rd2,           tbl[i].e_rd2);
      chk($sformatf("v%0d.pending", i),  32'(bus.pending),  32'(tbl[i].e_pend));
    end

    // async reset mid-drain: three loads parked behind ALU writes
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 1, 32'h10, 1, 5'(13 + k), 32'hD0 + 32'(k), 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 13, 0);
    #1;
    nvec++;
    chk("mid.pending", 32'(bus.pending), 3);
    chk("mid.we3",     32'(bus.we3),     1);
    chk("mid.wa3",     32'(bus.wa3),     13);
    chk("mid.rd1",     bus.rd1,          32'hD0);
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    chk("arst.pending",  32'(bus.pending),  0);
    chk("arst.ld_ready", 32'(bus.ld_ready), 1);
    chk("arst.we3",      32'(bus.we3),      0);
    chk("arst.rd1",      bus.rd1,           RF1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      nvec++;
      chk($sformatf("post%0d.we3", k),     32'(bus.we3),     0);
      chk($sformatf("post%0d.pending", k), 32'(bus.pending), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
